// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings, widths and MEM/WB record for the pipeline
package cpu_pkg;
    localparam int WORD        = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int GPR_ADDR_W  = 5;
    localparam int EXP_CODE_W  = 3;

    typedef enum logic [1:0] {
        MEM_OP_NOP = 2'd0,
        MEM_OP_LDW = 2'd1,
        MEM_OP_STW = 2'd2,
        MEM_OP_RSV = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_WRCR = 2'd1,
        CTRL_OP_EXRT = 2'd2,
        CTRL_OP_RSV  = 2'd3
    } ctrl_op_e;

    typedef enum logic [EXP_CODE_W-1:0] {
        EXP_NO_EXP     = 3'd0,
        EXP_EXT_INT    = 3'd1,
        EXP_UNDEF_INSN = 3'd2,
        EXP_OVERFLOW   = 3'd3,
        EXP_MISS_ALIGN = 3'd4,
        EXP_TRAP       = 3'd5,
        EXP_PRV_VIO    = 3'd6
    } exp_code_e;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_REQ    = 2'd1,
        BUS_ACCESS = 2'd2,
        BUS_DONE   = 2'd3
    } bus_state_e;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br_flag;
        logic [1:0]             ctrl_op;
        logic [GPR_ADDR_W-1:0]  dst_addr;
        logic                   gpr_we_;
        logic [EXP_CODE_W-1:0]  exp_code;
        logic [WORD-1:0]        out;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '{
        pc: '0, en: 1'b0, br_flag: 1'b0, ctrl_op: '0, dst_addr: '0,
        gpr_we_: 1'b1, exp_code: '0, out: '0
    };

    function automatic logic is_mem_access(input logic [1:0] op);
        return (op == MEM_OP_LDW) || (op == MEM_OP_STW);
    endfunction
endpackage

// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - request/grant bus master FSM with read-data latch and busy
module mem_bus_if
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   access_req,
    input  logic                   rw_read,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD-1:0]        wr_data,
    input  logic                   bus_grnt_,
    input  logic                   bus_rdy_,
    input  logic [WORD-1:0]        bus_rd_data,
    output logic                   bus_req_,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD-1:0]        bus_wr_data,
    output logic [WORD-1:0]        rd_data,
    output logic                   busy
);
    bus_state_e             state_q, state_d;
    logic                   bus_req_q, bus_req_d;
    logic                   bus_as_q, bus_as_d;
    logic                   bus_rw_q, bus_rw_d;
    logic [WORD_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [WORD-1:0]        bus_wr_data_q, bus_wr_data_d;
    logic [WORD-1:0]        rd_data_q, rd_data_d;
    logic                   busy_q, busy_d;

    // Bus outputs are decoded from the next state so they come straight from flops.
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            BUS_IDLE:   if (access_req) state_d = BUS_REQ;
            BUS_REQ:    if (!bus_grnt_) state_d = BUS_ACCESS;
            BUS_ACCESS: if (!bus_rdy_) begin
                rd_data_d = bus_rd_data;
                state_d   = BUS_DONE;
            end
            BUS_DONE:   if (!stall) state_d = BUS_IDLE;
            default:    state_d = BUS_IDLE;
        endcase
        bus_req_d     = !((state_d == BUS_REQ) || (state_d == BUS_ACCESS));
        bus_as_d      = (state_d != BUS_ACCESS);
        bus_rw_d      = (state_d == BUS_ACCESS) ? rw_read : 1'b1;
        bus_addr_d    = (state_d == BUS_ACCESS) ? addr : '0;
        bus_wr_data_d = (state_d == BUS_ACCESS) ? wr_data : '0;
        busy_d        = (state_d == BUS_REQ) || (state_d == BUS_ACCESS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BUS_IDLE;
            bus_req_q     <= 1'b1;
            bus_as_q      <= 1'b1;
            bus_rw_q      <= 1'b1;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
            busy_q        <= busy_d;
        end
    end

    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign rd_data     = rd_data_q;
    // The IDLE term lets the controller stall in the same cycle the access is seen.
    assign busy        = busy_q || ((state_q == BUS_IDLE) && access_req);
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: alignment check, result mux, MEM/WB register
module mem_stage
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   busy,
    input  logic [WORD_ADDR_W-1:0] ex_pc,
    input  logic                   ex_en,
    input  logic                   ex_br_flag,
    input  logic [1:0]             ex_mem_op,
    input  logic [WORD-1:0]        ex_mem_wr_data,
    input  logic [1:0]             ex_ctrl_op,
    input  logic [GPR_ADDR_W-1:0]  ex_dst_addr,
    input  logic                   ex_gpr_we_,
    input  logic [EXP_CODE_W-1:0]  ex_exp_code,
    input  logic [WORD-1:0]        ex_out,
    input  logic                   bus_grnt_,
    input  logic                   bus_rdy_,
    input  logic [WORD-1:0]        bus_rd_data,
    output logic                   bus_req_,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD-1:0]        bus_wr_data,
    output logic [WORD-1:0]        fwd_data,
    output logic [WORD_ADDR_W-1:0] mem_pc,
    output logic                   mem_en,
    output logic                   mem_br_flag,
    output logic [1:0]             mem_ctrl_op,
    output logic [GPR_ADDR_W-1:0]  mem_dst_addr,
    output logic                   mem_gpr_we_,
    output logic [EXP_CODE_W-1:0]  mem_exp_code,
    output logic [WORD-1:0]        mem_out
);
    logic            mem_access;
    logic            misaligned;
    logic            access_req;
    logic [WORD-1:0] rd_data;
    logic [WORD-1:0] result;
    logic [2:0]      exp_code;
    mem_wb_t         mem_wb_q, mem_wb_d;

    assign mem_access = ex_en && is_mem_access(ex_mem_op);
    assign misaligned = mem_access && (ex_out[1:0] != 2'b00);
    assign access_req = !reset && mem_access && (ex_out[1:0] == 2'b00);

    mem_bus_if u_bus_if (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .access_req  (access_req),
        .rw_read     (ex_mem_op == MEM_OP_LDW),
        .addr        (ex_out[WORD-1:2]),
        .wr_data     (ex_mem_wr_data),
        .bus_grnt_   (bus_grnt_),
        .bus_rdy_    (bus_rdy_),
        .bus_rd_data (bus_rd_data),
        .bus_req_    (bus_req_),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    always_comb begin
        exp_code = ex_exp_code;
        unique case (ex_mem_op)
            MEM_OP_LDW: result = rd_data;
            MEM_OP_STW: result = '0;
            default:    result = ex_out;
        endcase
        if (misaligned) begin
            result   = '0;
            exp_code = EXP_MISS_ALIGN;
        end
    end

    assign fwd_data = result;

    always_comb begin
        mem_wb_d = mem_wb_q;
        if (stall) begin
            mem_wb_d = mem_wb_q;
        end else if (flush) begin
            mem_wb_d = MEM_WB_BUBBLE;
        end else begin
            mem_wb_d.pc       = ex_pc;
            mem_wb_d.en       = ex_en;
            mem_wb_d.br_flag  = ex_br_flag;
            mem_wb_d.ctrl_op  = ex_ctrl_op;
            mem_wb_d.dst_addr = ex_dst_addr;
            mem_wb_d.gpr_we_  = ex_gpr_we_;
            mem_wb_d.exp_code = exp_code;
            mem_wb_d.out      = result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mem_wb_q <= MEM_WB_BUBBLE;
        else       mem_wb_q <= mem_wb_d;
    end

    assign mem_pc       = mem_wb_q.pc;
    assign mem_en       = mem_wb_q.en;
    assign mem_br_flag  = mem_wb_q.br_flag;
    assign mem_ctrl_op  = mem_wb_q.ctrl_op;
    assign mem_dst_addr = mem_wb_q.dst_addr;
    assign mem_gpr_we_  = mem_wb_q.gpr_we_;
    assign mem_exp_code = mem_wb_q.exp_code;
    assign mem_out      = mem_wb_q.out;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage with bus slave model
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset, stall_tb, flush;
    logic        stall, busy;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;
    logic        bus_grnt_, bus_rdy_;
    logic [31:0] bus_rd_data;
    logic        bus_req_, bus_as_, bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, fwd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;
    int gnt_dly = 0;
    int rdy_dly = 0;
    logic [31:0] smem [0:63];

    // The pipeline controller stalls whenever the stage reports busy.
    assign stall = stall_tb | busy;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_grnt_(bus_grnt_), .bus_rdy_(bus_rdy_), .bus_rd_data(bus_rd_data),
        .bus_req_(bus_req_), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .fwd_data(fwd_data),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_ex(input logic en, input logic [1:0] op, input logic [31:0] out,
                          input logic [31:0] wd);
        ex_en          = en;
        ex_mem_op      = op;
        ex_out         = out;
        ex_mem_wr_data = wd;
        ex_pc          = out[31:2] ^ 30'h155;
        ex_br_flag     = out[2];
        ex_ctrl_op     = out[3:2];
        ex_dst_addr    = out[6:2] ^ 5'd7;
        ex_gpr_we_     = (op != 2'd1);
        ex_exp_code    = 3'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus slave: grant after gnt_dly REQ cycles, ready after rdy_dly strobe cycles.
    initial begin
        int gcnt, rcnt;
        gcnt = 0; rcnt = 0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_rdy_ = 1'b1;
            bus_rd_data = '0;
            if (bus_req_ == 1'b0 && bus_as_ == 1'b1) begin
                bus_grnt_ = (gcnt >= gnt_dly) ? 1'b0 : 1'b1;
                gcnt++;
            end else begin
                bus_grnt_ = 1'b1;
                gcnt = 0;
            end
            if (bus_as_ == 1'b0) begin
                if (rcnt >= rdy_dly) begin
                    bus_rdy_ = 1'b0;
                    if (bus_rw) bus_rd_data = smem[bus_addr[5:0]];
                    else        smem[bus_addr[5:0]] = bus_wr_data;
                end
                rcnt++;
            end else begin
                rcnt = 0;
            end
        end
    end

    // Reference model: expected MEM/WB contents and stage result from the stage rules.
    logic [29:0] e_pc;
    logic        e_en, e_br, e_we_;
    logic [1:0]  e_ctrl;
    logic [4:0]  e_dst;
    logic [2:0]  e_exp;
    logic [31:0] e_out;

    function automatic logic model_misaligned();
        return ex_en && (ex_mem_op == 2'd1 || ex_mem_op == 2'd2) && ex_out[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] model_result();
        if (model_misaligned()) return 32'h0;
        if (ex_mem_op == 2'd1) return smem[ex_out[7:2]];
        if (ex_mem_op == 2'd2) return 32'h0;
        return ex_out;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_pc", {2'b0, mem_pc}, {2'b0, e_pc});
            check("m_en", {31'b0, mem_en}, {31'b0, e_en});
            check("m_br", {31'b0, mem_br_flag}, {31'b0, e_br});
            check("m_ctrl", {30'b0, mem_ctrl_op}, {30'b0, e_ctrl});
            check("m_dst", {27'b0, mem_dst_addr}, {27'b0, e_dst});
            check("m_we", {31'b0, mem_gpr_we_}, {31'b0, e_we_});
            check("m_exp", {29'b0, mem_exp_code}, {29'b0, e_exp});
            check("m_out", mem_out, e_out);
            if (!stall && !reset) check("m_fwd", fwd_data, model_result());
            if (!bus_as_) begin
                check("m_bus_addr", {2'b0, bus_addr}, {2'b0, ex_out[31:2]});
                check("m_bus_rw", {31'b0, bus_rw}, {31'b0, ex_mem_op == 2'd1});
                check("m_bus_req", {31'b0, bus_req_}, 32'h0);
                if (ex_mem_op == 2'd2) check("m_bus_wd", bus_wr_data, ex_mem_wr_data);
            end
        end
        if (reset || (!stall && flush)) begin
            e_pc = '0; e_en = 1'b0; e_br = 1'b0; e_ctrl = '0; e_dst = '0;
            e_we_ = 1'b1; e_exp = '0; e_out = '0;
        end else if (!stall) begin
            e_pc = ex_pc; e_en = ex_en; e_br = ex_br_flag; e_ctrl = ex_ctrl_op;
            e_dst = ex_dst_addr; e_we_ = ex_gpr_we_;
            e_exp = model_misaligned() ? 3'd4 : ex_exp_code;
            e_out = model_result();
        end
    end

    task automatic run_access(input int max_cyc, output int nbusy, output logic [29:0] a_seen,
                              output logic rw_seen, output logic [31:0] wd_seen,
                              output logic as_early);
        logic saw_gnt;
        saw_gnt = 1'b0; nbusy = 0; a_seen = '0; rw_seen = 1'b0; wd_seen = '0; as_early = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            if (!bus_as_) begin
                a_seen = bus_addr; rw_seen = bus_rw; wd_seen = bus_wr_data;
                if (!saw_gnt) as_early = 1'b1;
            end
            if (!bus_grnt_) saw_gnt = 1'b1;
        end
        if (busy) check("access_timeout", 32'd1, 32'd0);
        tick();
        set_ex(1'b0, 2'd0, 32'h0, 32'h0);
    endtask

    initial begin
        int nb;
        logic [29:0] a;
        logic rw, early;
        logic [31:0] wd;
        bit seen_as;
        for (int i = 0; i < 64; i++) smem[i] = 32'h0;
        smem[4] = 32'hDEADBEEF;
        reset = 1'b1; stall_tb = 1'b0; flush = 1'b0;
        set_ex(1'b0, 2'd0, 32'h0, 32'h0);
        tick(); tick();
        @(negedge clk);
        check("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_gpr_we", {31'b0, mem_gpr_we_}, 32'h1);
        check("rst_bus_req", {31'b0, bus_req_}, 32'h1);
        check("rst_busy", {31'b0, busy}, 32'h0);
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // LDW, immediate grant and ready
        gnt_dly = 0; rdy_dly = 0;
        set_ex(1'b1, 2'd1, 32'h10, 32'h0);
        run_access(40, nb, a, rw, wd, early);
        check("ldw_busy_cycles", nb, 32'd3);
        check("ldw_addr", {2'b0, a}, 32'h4);
        check("ldw_rw", {31'b0, rw}, 32'h1);
        @(negedge clk);
        check("ldw_mem_out", mem_out, 32'hDEADBEEF);

        // STW with grant held off four REQ cycles
        tick();
        gnt_dly = 4;
        set_ex(1'b1, 2'd2, 32'h20, 32'h12345678);
        run_access(40, nb, a, rw, wd, early);
        check("stw_busy_cycles", nb, 32'd7);
        check("stw_as_before_gnt", {31'b0, early}, 32'h0);
        check("stw_rw", {31'b0, rw}, 32'h0);
        check("stw_wd", wd, 32'h12345678);
        @(negedge clk);
        check("stw_mem_out", mem_out, 32'h0);

        // LDW reading back the stored word, ready delayed
        tick();
        gnt_dly = 0; rdy_dly = 2;
        set_ex(1'b1, 2'd1, 32'h20, 32'h0);
        run_access(40, nb, a, rw, wd, early);
        check("ldw2_busy_cycles", nb, 32'd5);
        @(negedge clk);
        check("ldw2_mem_out", mem_out, 32'h12345678);

        // misaligned LDW: no bus activity, MISS_ALIGN
        tick();
        set_ex(1'b1, 2'd1, 32'h13, 32'h0);
        @(negedge clk);
        check("mis_busy", {31'b0, busy}, 32'h0);
        check("mis_req", {31'b0, bus_req_}, 32'h1);
        tick();
        @(negedge clk);
        check("mis_exp", {29'b0, mem_exp_code}, 32'h4);
        check("mis_out", mem_out, 32'h0);
        check("mis_req2", {31'b0, bus_req_}, 32'h1);

        // stall / flush priority on the MEM/WB register
        tick();
        set_ex(1'b1, 2'd0, 32'h55, 32'h0);
        tick();
        stall_tb = 1'b1;
        set_ex(1'b1, 2'd0, 32'd10 + 32'd20, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        check("stall_hold", mem_out, 32'h55);
        tick();
        flush = 1'b1;
        tick();
        @(negedge clk);
        check("stall_flush_hold", mem_out, 32'h55);
        check("stall_flush_en", {31'b0, mem_en}, 32'h1);
        tick();
        stall_tb = 1'b0;
        tick();
        @(negedge clk);
        check("flush_en", {31'b0, mem_en}, 32'h0);
        check("flush_we", {31'b0, mem_gpr_we_}, 32'h1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("nop_fwd", fwd_data, 32'd30);
        tick();
        @(negedge clk);
        check("nop_mem_out", mem_out, 32'd30);

        // flush held through an LDW access: transaction completes, bubble loaded
        tick();
        rdy_dly = 3;
        flush = 1'b1;
        set_ex(1'b1, 2'd1, 32'h10, 32'h0);
        run_access(40, nb, a, rw, wd, early);
        flush = 1'b0;
        check("flush_acc_busy", nb, 32'd6);
        check("flush_acc_addr", {2'b0, a}, 32'h4);
        @(negedge clk);
        check("flush_acc_en", {31'b0, mem_en}, 32'h0);
        check("flush_acc_out", mem_out, 32'h0);

        // reset while a STW is in ACCESS
        tick();
        set_ex(1'b1, 2'd0, 32'h7, 32'h0);
        tick();
        rdy_dly = 10;
        set_ex(1'b1, 2'd2, 32'h24, 32'hCAFEF00D);
        seen_as = 1'b0;
        for (int i = 0; i < 20 && !seen_as; i++) begin
            @(negedge clk);
            if (!bus_as_) seen_as = 1'b1;
        end
        check("rst_acc_reached", {31'b0, seen_as}, 32'h1);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("rst_acc_req", {31'b0, bus_req_}, 32'h1);
        check("rst_acc_as", {31'b0, bus_as_}, 32'h1);
        check("rst_acc_busy", {31'b0, busy}, 32'h0);
        check("rst_acc_we", {31'b0, mem_gpr_we_}, 32'h1);
        check("rst_acc_en", {31'b0, mem_en}, 32'h0);
        tick();
        set_ex(1'b0, 2'd0, 32'h0, 32'h0);
        reset = 1'b0;
        tick(); tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline, directly downstream of stage_EX.
- Consumes the EX/MEM pipeline register (ex_* signals).
- Performs word loads and stores over the shared request/grant bus, checks alignment, and produces the MEM/WB pipeline register plus a forwarding value.
- Raises busy to the pipeline controller while a bus transaction is outstanding.

Parameters:
- WORD, 32, data word width
- WORD_ADDR_W, 30, word address width
- GPR_ADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the MEM/WB register
- flush  in  1  load a bubble into the MEM/WB register
- busy  out  1  bus access in progress; the controller stalls the pipeline
- ex_pc  in  30  instruction PC
- ex_en  in  1  EX/MEM data valid
- ex_br_flag  in  1  branch flag
- ex_mem_op  in  2  0=NOP, 1=LDW, 2=STW, 3=reserved (treated as NOP)
- ex_mem_wr_data  in  32  store data
- ex_ctrl_op  in  2  control-register op, passed through
- ex_dst_addr  in  5  GPR write address
- ex_gpr_we_  in  1  GPR write enable, active-low
- ex_exp_code  in  3  exception code
- ex_out  in  32  ALU result; byte address for LDW/STW
- bus_grnt_  in  1  bus grant, active-low
- bus_rdy_  in  1  bus ready, active-low
- bus_rd_data  in  32  read data
- bus_req_  out  1  bus request, active-low
- bus_as_  out  1  address strobe, active-low
- bus_rw  out  1  1=read, 0=write
- bus_addr  out  30  word address
- bus_wr_data  out  32  write data
- fwd_data  out  32  combinational stage result, for forwarding to ID
- mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out  out  (widths as ex_*)  MEM/WB register

Behaviour:
- Access required when: ex_en=1, ex_mem_op is LDW or STW, and ex_out[1:0]=0.
- Misalignment: ex_en=1, op LDW/STW, ex_out[1:0]!=0.
  - No bus access is made.
  - Result = 0; exp_code becomes MISS_ALIGN (4).
- Result mux (feeds fwd_data and mem_out):
  - LDW: latched read data
  - STW: 0
  - NOP/reserved: ex_out
  - Misaligned: 0
- Bus FSM, states IDLE, REQ, ACCESS, DONE:
  - IDLE: if an access is required, busy=1 combinationally and next state is REQ; otherwise bus outputs are idle.
  - REQ: bus_req_=0, busy=1. Go to ACCESS when bus_grnt_=0.
  - ACCESS: bus_req_=0, bus_as_=0, bus_addr=ex_out[31:2], bus_rw=(op==LDW), bus_wr_data=ex_mem_wr_data, busy=1. When bus_rdy_=0, latch bus_rd_data and go to DONE.
  - DONE: busy=0 and bus idle. Go to IDLE on the first cycle with stall=0. No new access starts from DONE.
- Idle bus values: bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0.
- Minimum access cost: 3 busy cycles (IDLE, REQ, ACCESS) with grant and ready both returned in one cycle.
- The controller holds ex_* stable while busy=1.
- MEM/WB register, updated on posedge clk:
  - reset: mem_en=0, mem_gpr_we_=1, mem_exp_code=0, all other outputs 0.
  - stall=1: hold all values.
  - flush=1 (and stall=0): bubble, i.e. the reset values.
  - Otherwise: pass ex_* through, with mem_out=result and exp_code as computed.
  - stall has priority over flush.
- Flush during an access: the bus transaction always runs to completion (no abort). The flush applies when the register next updates.
- Reset during REQ/ACCESS: FSM goes to IDLE and bus signals deassert in the following cycle.
- bus_rdy_ is ignored outside ACCESS; bus_grnt_ is ignored outside REQ.

Decomposition:
- Shared package cpu_pkg holds:
  - mem_op encodings (NOP/LDW/STW)
  - ctrl_op encodings
  - exception codes: NO_EXP=0, EXT_INT=1, UNDEF_INSN=2, OVERFLOW=3, MISS_ALIGN=4, TRAP=5, PRV_VIO=6
  - bus FSM state encoding
  - width constants
- One sub-module, mem_bus_if: the FSM, bus outputs, read-data latch and busy.
- The top level holds the alignment check, result mux and MEM/WB register.

Test Plan:
- Reset mid-ACCESS (STW in flight) -> next cycle bus_req_=1, bus_as_=1, busy=0, mem_gpr_we_=1, mem_en=0.
- LDW, ex_out=0x00000010, grant and ready immediate, bus_rd_data=0xDEADBEEF -> bus_addr=0x4, bus_rw=1, busy high 3 cycles, mem_out=0xDEADBEEF after stall release.
- STW, ex_out=0x20, ex_mem_wr_data=0x12345678, grant delayed 4 cycles -> bus_as_ low only after bus_grnt_=0, bus_rw=0, bus_wr_data=0x12345678, mem_out=0.
- LDW, ex_out=0x13 -> no bus_req_, busy=0, mem_exp_code=4, mem_out=0.
- NOP with ex_out=30 (inputs 10+20): stall=1 for 5 cycles holds the previous mem_out; flush=1 gives a bubble; stall=1 with flush=1 holds; stall=0/flush=0 gives mem_out=30 and fwd_data=30.
- flush asserted during ACCESS of an LDW -> bus transaction completes, and MEM/WB loads a bubble on the update cycle.
